// File: rtl/bj_pkg.sv
// Shared blackjack definitions: deck geometry, rank constants, FSM encoding and
// the rank/index helper functions used by the shoe and later by the datapath.
package bj_pkg;

  localparam int DECK_SIZE = 52;
  localparam logic [5:0] DECK_FULL = 6'(DECK_SIZE);
  localparam logic [5:0] DECK_LAST = 6'(DECK_SIZE - 1);

  localparam logic [3:0] RANK_ACE  = 4'd1;
  localparam logic [3:0] RANK_JACK = 4'd11;
  localparam logic [3:0] RANK_KING = 4'd13;

  localparam logic [1:0] ST_INIT_ENC    = 2'd0;
  localparam logic [1:0] ST_SHUFFLE_ENC = 2'd1;
  localparam logic [1:0] ST_READY_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT    = ST_INIT_ENC,
    ST_SHUFFLE = ST_SHUFFLE_ENC,
    ST_READY   = ST_READY_ENC
  } state_t;

  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd10 : rank;
  endfunction

  // Smallest 2^n-1 covering i, so the masked random draw rejects rarely.
  function automatic logic [5:0] idx_mask(input logic [5:0] i);
    if (i <= 6'd1)       return 6'd1;
    else if (i <= 6'd3)  return 6'd3;
    else if (i <= 6'd7)  return 6'd7;
    else if (i <= 6'd15) return 6'd15;
    else if (i <= 6'd31) return 6'd31;
    else                 return 6'd63;
  endfunction

  function automatic logic [3:0] init_rank(input logic [5:0] k);
    return k[5:2] + 4'd1;
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Draw/shuffle handshake between the game controller (master) and the shoe (slave).
interface card_shoe_if;
  logic       shuffle_req;
  logic       draw_req;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic       busy;
  logic       empty;
  logic [5:0] remaining;
  logic       draw_err;

  modport master (
    output shuffle_req, draw_req,
    input  card_valid, card_rank, card_value, busy, empty, remaining, draw_err
  );

  modport slave (
    input  shuffle_req, draw_req,
    output card_valid, card_rank, card_value, busy, empty, remaining, draw_err
  );
endinterface

// File: rtl/bj_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); a zero seed is forced to 1.
module bj_lfsr16 (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] r_q;
  logic [15:0] w_seed;

  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (!resetn) r_q <= w_seed;
    else         r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? 16'hB400 : 16'h0000);
  end

  assign q = r_q;
endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: builds an ordered deck, Fisher-Yates shuffles it with an LFSR,
// then deals one card per draw request through a two-stage output pipeline.
module card_shoe
  import bj_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic        clk,
  input logic        resetn,
  card_shoe_if.slave bus
);
  state_t      r_state, w_next;
  logic [3:0]  r_deck [DECK_SIZE];
  logic [5:0]  r_idx;
  logic [5:0]  r_ptr;
  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;
  logic [5:0]  w_j;
  logic        w_swap, w_draw_ok, w_draw_err;

  logic        r_vld_p0, r_err_p0;
  logic [3:0]  r_rank_p0;
  logic        r_card_valid, r_draw_err, r_busy, r_empty;
  logic [3:0]  r_card_rank, r_card_value;
  logic [5:0]  r_remaining;

  bj_lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .seed   (SEED),
    .q      (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[15:6];
  assign w_j        = w_lfsr[5:0] & idx_mask(r_idx);
  assign w_swap     = (r_state == ST_SHUFFLE) && (w_j <= r_idx);
  assign w_draw_ok  = (r_state == ST_READY) && !bus.shuffle_req && bus.draw_req && (r_ptr != DECK_FULL);
  assign w_draw_err = (r_state == ST_READY) && !bus.shuffle_req && bus.draw_req && (r_ptr == DECK_FULL);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_INIT;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:    if (r_idx == DECK_LAST) w_next = ST_SHUFFLE;
      ST_SHUFFLE: if (w_swap && (r_idx == 6'd1)) w_next = ST_READY;
      ST_READY:   if (bus.shuffle_req) w_next = ST_INIT;
      default:    w_next = ST_INIT;
    endcase
  end

  // r_idx is the build index k in INIT and the Fisher-Yates index i in SHUFFLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_idx <= 6'd0;
      r_ptr <= 6'd0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_idx != DECK_LAST) r_idx <= r_idx + 6'd1;
        end
        ST_SHUFFLE: begin
          if (w_swap) begin
            if (r_idx == 6'd1) r_ptr <= 6'd0;
            else               r_idx <= r_idx - 6'd1;
          end
        end
        ST_READY: begin
          if (bus.shuffle_req) r_idx <= 6'd0;
          else if (w_draw_ok)  r_ptr <= r_ptr + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      ST_INIT: r_deck[r_idx] <= init_rank(r_idx);
      ST_SHUFFLE: begin
        if (w_swap) begin
          r_deck[r_idx] <= r_deck[w_j];
          r_deck[w_j]   <= r_deck[r_idx];
        end
      end
      default: ;
    endcase
  end

  // Stage p0: capture the dealt card / error at the request edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld_p0 <= 1'b0;
      r_err_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_draw_ok;
      r_err_p0 <= w_draw_err;
    end
    if (w_draw_ok) r_rank_p0 <= r_deck[r_ptr];
  end

  // Stage p1: registered outputs; status reflects state/ptr after the p0 edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_card_valid <= 1'b0;
      r_draw_err   <= 1'b0;
      r_card_rank  <= 4'd0;
      r_card_value <= 4'd0;
      r_busy       <= 1'b1;
      r_empty      <= 1'b0;
      r_remaining  <= 6'd0;
    end else begin
      r_card_valid <= r_vld_p0;
      r_draw_err   <= r_err_p0;
      if (r_vld_p0) begin
        r_card_rank  <= r_rank_p0;
        r_card_value <= rank_to_value(r_rank_p0);
      end
      r_busy      <= (r_state != ST_READY);
      r_empty     <= (r_state == ST_READY) && (r_ptr == DECK_FULL);
      r_remaining <= (r_state == ST_READY) ? (DECK_FULL - r_ptr) : 6'd0;
    end
  end

  assign bus.card_valid = r_card_valid;
  assign bus.draw_err   = r_draw_err;
  assign bus.card_rank  = r_card_rank;
  assign bus.card_value = r_card_value;
  assign bus.busy       = r_busy;
  assign bus.empty      = r_empty;
  assign bus.remaining  = r_remaining;
endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: draws push expected strobes, a monitor pops and checks.
module tb_card_shoe;
  logic clk = 1'b0;
  logic rstn;
  logic rst_aux;

  always #5 clk = ~clk;

  card_shoe_if bus_m();
  card_shoe_if bus_s();
  card_shoe_if bus_z();
  card_shoe_if bus_o();

  card_shoe u_dut (.clk(clk), .resetn(rstn), .bus(bus_m));
  card_shoe #(.SEED(16'h1234)) u_seed (.clk(clk), .resetn(rst_aux), .bus(bus_s));
  card_shoe #(.SEED(16'h0000)) u_zero (.clk(clk), .resetn(rst_aux), .bus(bus_z));
  card_shoe #(.SEED(16'h0001)) u_one  (.clk(clk), .resetn(rst_aux), .bus(bus_o));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit is_err;
    int rem;
    int cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         hist[14];
  int         val_sum = 0;
  logic [3:0] last_rank = 4'd0;
  logic [3:0] s_cards[$];
  logic [3:0] z_cards[$];
  logic [3:0] o_cards[$];
  logic [3:0] run1[10];
  int         cycles;

  function automatic int model_value(input int r);
    return (r > 10) ? 10 : r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (bus_m.busy !== 1'b0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (bus_m.busy !== 1'b0) begin
      chk("ready_timeout", 32'(bus_m.busy), 32'd0);
      finish_now();
    end
  endtask

  task automatic wait_aux_ready();
    int cnt = 0;
    while ((bus_s.busy !== 1'b0 || bus_z.busy !== 1'b0 || bus_o.busy !== 1'b0) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (bus_s.busy !== 1'b0 || bus_z.busy !== 1'b0 || bus_o.busy !== 1'b0) begin
      chk("aux_ready_timeout", 32'({bus_s.busy, bus_z.busy, bus_o.busy}), 32'd0);
      finish_now();
    end
  endtask

  task automatic push_draw(input bit is_err, input int rem);
    exp_t e;
    e.is_err = is_err;
    e.rem    = rem;
    e.cyc    = cyc + 2;
    sbq.push_back(e);
  endtask

  task automatic aux_draws(input int n);
    for (int k = 0; k < n; k++) begin
      bus_s.draw_req = 1'b1;
      bus_z.draw_req = 1'b1;
      bus_o.draw_req = 1'b1;
      @(negedge clk);
    end
    bus_s.draw_req = 1'b0;
    bus_z.draw_req = 1'b0;
    bus_o.draw_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe from the main shoe must match the oldest expectation.
  always @(negedge clk) begin
    if (bus_m.card_valid === 1'b1 || bus_m.draw_err === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 32'({bus_m.card_valid, bus_m.draw_err}), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("strobe_draw_err", 32'(bus_m.draw_err), 32'(mon_e.is_err));
        chk("strobe_card_valid", 32'(bus_m.card_valid), 32'(!mon_e.is_err));
        chk("strobe_remaining", 32'(bus_m.remaining), 32'(mon_e.rem));
        if (!mon_e.is_err) begin
          chk("card_value", 32'(bus_m.card_value), 32'(model_value(int'(bus_m.card_rank))));
          chk("card_rank_range", 32'(bus_m.card_rank >= 4'd1 && bus_m.card_rank <= 4'd13), 32'd1);
          if (bus_m.card_rank >= 4'd1 && bus_m.card_rank <= 4'd13)
            hist[int'(bus_m.card_rank)]++;
          val_sum   += int'(bus_m.card_value);
          last_rank  = bus_m.card_rank;
        end else begin
          chk("err_rank_hold", 32'(bus_m.card_rank), 32'(last_rank));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_s.card_valid === 1'b1) s_cards.push_back(bus_s.card_rank);
    if (bus_z.card_valid === 1'b1) z_cards.push_back(bus_z.card_rank);
    if (bus_o.card_valid === 1'b1) o_cards.push_back(bus_o.card_rank);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn    = 1'b0;
    rst_aux = 1'b0;
    bus_m.shuffle_req = 1'b0; bus_m.draw_req = 1'b0;
    bus_s.shuffle_req = 1'b0; bus_s.draw_req = 1'b0;
    bus_z.shuffle_req = 1'b0; bus_z.draw_req = 1'b0;
    bus_o.shuffle_req = 1'b0; bus_o.draw_req = 1'b0;
    for (int r = 0; r < 14; r++) hist[r] = 0;
    repeat (3) @(negedge clk);

    chk("rst_busy",       32'(bus_m.busy),       32'd1);
    chk("rst_remaining",  32'(bus_m.remaining),  32'd0);
    chk("rst_empty",      32'(bus_m.empty),      32'd0);
    chk("rst_card_valid", 32'(bus_m.card_valid), 32'd0);
    chk("rst_card_rank",  32'(bus_m.card_rank),  32'd0);
    chk("rst_card_value", 32'(bus_m.card_value), 32'd0);
    chk("rst_draw_err",   32'(bus_m.draw_err),   32'd0);

    rstn = 1'b1;
    wait_ready(cycles);
    chk("build_shuffle_min_cycles", 32'(cycles >= 103), 32'd1);
    chk("ready_remaining", 32'(bus_m.remaining), 32'd52);
    chk("ready_empty",     32'(bus_m.empty),     32'd0);

    // Single draw: one strobe, remaining 52 -> 51.
    bus_m.draw_req = 1'b1;
    push_draw(1'b0, 51);
    @(negedge clk);
    bus_m.draw_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("single_strobe_width", 32'(bus_m.card_valid), 32'd0);

    // Remaining 51 cards back to back.
    for (int k = 0; k < 51; k++) begin
      bus_m.draw_req = 1'b1;
      push_draw(1'b0, 50 - k);
      @(negedge clk);
    end
    bus_m.draw_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained_deck", 32'(sbq.size()), 32'd0);
    for (int r = 1; r <= 13; r++) chk($sformatf("rank_%0d_count", r), 32'(hist[r]), 32'd4);
    chk("value_sum", 32'(val_sum), 32'd340);
    chk("empty_after_52",     32'(bus_m.empty),     32'd1);
    chk("remaining_after_52", 32'(bus_m.remaining), 32'd0);

    // Draw on an empty shoe.
    bus_m.draw_req = 1'b1;
    push_draw(1'b1, 0);
    @(negedge clk);
    bus_m.draw_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained_err", 32'(sbq.size()), 32'd0);
    chk("empty_hold", 32'(bus_m.empty), 32'd1);

    // Shuffle and draw in the same cycle: shuffle wins, no strobe.
    bus_m.shuffle_req = 1'b1;
    bus_m.draw_req    = 1'b1;
    @(negedge clk);
    bus_m.shuffle_req = 1'b0;
    bus_m.draw_req    = 1'b0;
    @(negedge clk);
    chk("busy_after_shuffle", 32'(bus_m.busy), 32'd1);
    repeat (5) @(negedge clk);
    bus_m.draw_req = 1'b1;
    @(negedge clk);
    bus_m.draw_req = 1'b0;
    wait_ready(cycles);
    chk("reshuffle_remaining", 32'(bus_m.remaining), 32'd52);
    chk("reshuffle_empty",     32'(bus_m.empty),     32'd0);

    // Reset in the middle of SHUFFLE.
    bus_m.shuffle_req = 1'b1;
    @(negedge clk);
    bus_m.shuffle_req = 1'b0;
    repeat (80) @(negedge clk);
    chk("busy_mid_shuffle", 32'(bus_m.busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("busy_after_mid_reset", 32'(bus_m.busy), 32'd1);
    wait_ready(cycles);
    chk("mid_reset_rebuild_min_cycles", 32'(cycles >= 103), 32'd1);
    chk("mid_reset_remaining", 32'(bus_m.remaining), 32'd52);

    bus_m.draw_req = 1'b1;
    push_draw(1'b0, 51);
    @(negedge clk);
    bus_m.draw_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained_post_reset", 32'(sbq.size()), 32'd0);

    // Seed runs: 0x1234 twice, and seed 0 against seed 1.
    repeat (2) @(negedge clk);
    rst_aux = 1'b1;
    wait_aux_ready();
    aux_draws(52);
    chk("seed0_card_count", 32'(z_cards.size()), 32'd52);
    chk("seed1_card_count", 32'(o_cards.size()), 32'd52);
    for (int k = 0; k < 52; k++)
      if (k < z_cards.size() && k < o_cards.size())
        chk($sformatf("seed0_vs_seed1_card_%0d", k), 32'(z_cards[k]), 32'(o_cards[k]));
    chk("seed1234_run1_count", 32'(s_cards.size()), 32'd52);
    for (int k = 0; k < 10; k++) run1[k] = (k < s_cards.size()) ? s_cards[k] : 4'd0;

    rst_aux = 1'b0;
    @(negedge clk);
    rst_aux = 1'b1;
    s_cards.delete();
    z_cards.delete();
    o_cards.delete();
    wait_aux_ready();
    aux_draws(10);
    chk("seed1234_run2_count", 32'(s_cards.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      if (k < s_cards.size())
        chk($sformatf("seed1234_repeat_card_%0d", k), 32'(s_cards[k]), 32'(run1[k]));

    chk("sb_drained_final", 32'(sbq.size()), 32'd0);
    finish_now();
  end
endmodule

// File: doc/card_shoe.md
# card_shoe

Shuffled 52-card shoe that answers the game controller's draw requests: one request in, one card out with its blackjack point value. It replaces free-running counter card generation with a real deck, so there are no impossible repeats and every rank appears exactly four times per shoe. It sits between the game control FSM, which initiates draws and reshuffles, and the datapath, which accumulates totals.

## Interface
- SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'h0001.
- clk  in  1  system clock (CLOCK_50); rising edge.
- resetn  in  1  reset, synchronous, active-low.
- shuffle_req  in  1  single-cycle request to rebuild and reshuffle the shoe.
- draw_req  in  1  single-cycle request for the next card.
- card_valid  out  1  one-cycle strobe; card_rank and card_value are valid while it is high.
- card_rank  out  4  1 = ace, 2..10, 11 = J, 12 = Q, 13 = K; holds its value between strobes.
- card_value  out  4  points: ace = 1, 2..10 = rank, J/Q/K = 10; the controller handles ace-as-11.
- busy  out  1  high in INIT or SHUFFLE; draw_req is ignored while busy is high.
- empty  out  1  high in READY when no cards remain.
- remaining  out  6  cards left to deal: 0..52.
- draw_err  out  1  one-cycle strobe for a draw_req that arrives in READY while the shoe is empty.

## Operation
- The deck is deck[0..51] (4-bit ranks), with deal pointer ptr (6 bits) and shuffle index i (6 bits).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It advances every cycle in every state and loads SEED on reset.
- FSM states: INIT, SHUFFLE, READY. The reset state is INIT.
- INIT:
  - Writes deck[k] = k/4 + 1, one entry per cycle, k = 0..51.
  - After k = 51: i <= 51 and the FSM moves to SHUFFLE.
- SHUFFLE (Fisher-Yates):
  - j = lfsr[5:0] & mask(i), where mask(i) is the smallest 2^n-1 >= i.
  - If j <= i: swap deck[i] and deck[j], then decrement i. Otherwise retry on the next cycle.
  - After the swap at i = 1: ptr <= 0 and the FSM moves to READY.
- READY, in priority order:
  1. shuffle_req: go to INIT and drop draw_req in the same cycle.
  2. draw_req with ptr < 52: capture deck[ptr] and increment ptr.
  3. draw_req with ptr = 52: pulse draw_err. No card is output.
- shuffle_req in INIT or SHUFFLE is ignored; the shuffle already in progress completes.
- remaining = 52 - ptr in READY and 0 otherwise. empty = READY && ptr == 52.

## Timing
- Reset values: card_valid 0, card_rank 0, card_value 0, draw_err 0, busy 1, empty 0, remaining 0. State INIT, ptr 0.
- Reset takes effect from any state on the next edge, including mid-shuffle. The partial deck is discarded.
- INIT lasts exactly 52 cycles. SHUFFLE lasts at least 51 cycles, averaging under 2 tries per index. The bench bound is 1000 cycles from reset release to busy = 0.
- Draw latency is 1 cycle: draw_req sampled at edge t gives card_valid high for exactly the cycle after edge t+1.
  - remaining decrements in that same cycle.
  - Back-to-back draw_req on consecutive cycles gives consecutive card_valid strobes.
- A shuffle_req sampled at edge t gives busy = 1 from the cycle after edge t+1.
- draw_err follows the same 1-cycle latency as card_valid.

## Structure
- Shared package bj_pkg:
  - DECK_SIZE = 52
  - RANK_ACE = 1, RANK_JACK = 11, RANK_KING = 13
  - state encoding localparams
  - function rank_to_value(rank), which returns 10 for rank >= 10 and rank otherwise
- Sub-module bj_lfsr16: ports clk, resetn, seed, q[15:0]. It is reused by the datapath if that later needs dealer randomness.
- The deck is a 52x4 register array, not RAM, because the shuffle swaps two entries in one cycle.

## Test plan
- Reset, then wait for busy = 0 (within 1000 cycles) -> remaining = 52, empty = 0. Draw 52 times -> each rank 1..13 appears exactly 4 times and the sum of card_value is 340.
- draw_req pulse at READY cycle t -> card_valid high for exactly one cycle at t+1, card_value = rank_to_value(card_rank), remaining 52 -> 51.
- Draw 52 cards, then one more draw_req -> empty = 1, remaining = 0, draw_err pulses once, card_valid stays 0, card_rank holds the last card.
- shuffle_req and draw_req in the same READY cycle -> no card_valid, busy = 1 the next cycle, and after the shoe rebuilds remaining = 52.
- resetn low for one cycle mid-SHUFFLE -> busy stays 1, INIT restarts and lasts 52 cycles, and no card_valid appears before READY.
- Two runs with SEED = 16'h1234 -> identical first 10 cards. Runs with SEED = 0 and SEED = 1 -> identical decks.
